// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial-adder FSM state encoding and opcode values.
package alu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_add.sv
// 1-bit full-adder cell, time-shared by the serial add/subtract controller.
module add (
  input  logic src1,
  input  logic src2,
  input  logic cin,
  output logic cout,
  output logic result
);

  assign result = src1 ^ src2 ^ cin;
  assign cout   = (src1 & src2) | (cin & (src1 ^ src2));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer around a single full-adder cell.
// Optional zero flag output enabled by defining SERIAL_ADD_ZERO_FLAG_EN.
//
// state | meaning
// IDLE  | ready for a command, result holds last value
// RUN   | one operand bit per clock through the cell, LSB first
// DONE  | result and flags valid, waiting for result_ready
module serial_add_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             sub,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
`ifdef SERIAL_ADD_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_q, res_shift;
  logic [CW-1:0]    cnt;
  logic             carry, c_msb_in;
  logic             cell_sum, cell_cout;
  logic             accept, last_bit;

  add u_cell (
    .src1   (a_sh[0]),
    .src2   (b_sh[0]),
    .cin    (carry),
    .cout   (cell_cout),
    .result (cell_sum)
  );

  assign last_bit = (state == RUN) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sum bits enter at the MSB so the LSB-first result lands aligned after WIDTH shifts.
  always_comb begin
    res_shift            = res_q >> 1;
    res_shift[WIDTH-1]   = cell_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_q    <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
    end else if (accept) begin
      a_sh  <= src1;
      b_sh  <= (sub == OP_SUB) ? ~src2 : src2;
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      res_q <= res_shift;
      carry <= cell_cout;
      cnt   <= cnt + CW'(1);
      if (last_bit) c_msb_in <= carry;
    end
  end

  assign result   = res_q;
  assign cout     = (state == DONE) & carry;
  assign overflow = (state == DONE) & (c_msb_in ^ carry);

`ifdef SERIAL_ADD_ZERO_FLAG_EN
  logic nonzero;

  always_ff @(posedge clk) begin
    if (rst)                nonzero <= 1'b0;
    else if (accept)        nonzero <= 1'b0;
    else if (state == RUN)  nonzero <= nonzero | cell_sum;
  end

  assign zero = (state == DONE) & ~nonzero;
`endif

endmodule
